// File: rtl/hm01b0_strip_capture_ctrl.sv
// HM01B0 frame-capture sequencer: aligns to a frame boundary and fills a two-bank
// strip buffer, presenting each full bank to the JPEG block encoder.
module hm01b0_strip_capture_ctrl #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int STRIP_ROWS = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              mclk,
    input  logic              nreset,
    input  logic              i_cam_hsync,
    input  logic              i_cam_vsync,
    input  logic [7:0]        i_cam_pixdata,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_strip_done,
    output logic              o_wr_en,
    output logic              o_wr_bank,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_strip_ready,
    output logic              o_strip_bank,
    output logic [4:0]        o_strip_index,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic              o_short_frame
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int RIS_W = $clog2(STRIP_ROWS + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_END = COL_W'(WIDTH);
    localparam logic [RIS_W-1:0] RIS_END = RIS_W'(STRIP_ROWS);
    localparam logic [ROW_W-1:0] ROW_END = ROW_W'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    function automatic logic [ADDR_W-1:0] strip_addr(input logic [RIS_W-1:0] ris,
                                                     input logic [COL_W-1:0] col);
        strip_addr = ADDR_W'(ris) * ADDR_W'(WIDTH) + ADDR_W'(col);
    endfunction

    state_t            r_state;
    logic              r_hsync_d;
    logic              r_vsync_d;
    logic [COL_W-1:0]  r_col;
    logic [RIS_W-1:0]  r_ris;
    logic [ROW_W-1:0]  r_rows;
    logic [4:0]        r_sidx;
    logic              r_fill;
    logic              r_present;
    logic [1:0]        r_full;
    logic [4:0]        r_snum [2];
    logic              r_wr_en;
    logic              r_wr_bank;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_overflow;
    logic              r_short;

    // The first vsync-high cycle in ARMED is already a capture cycle, seen with
    // all per-frame counters as if cleared.
    logic              w_first;
    logic              w_cap;
    logic [COL_W-1:0]  w_col;
    logic [RIS_W-1:0]  w_ris;
    logic [RIS_W-1:0]  w_ris_nxt;
    logic [ROW_W-1:0]  w_rows;
    logic [ROW_W-1:0]  w_rows_nxt;
    logic [4:0]        w_sidx;
    logic              w_fill;
    logic              w_nfill;
    logic              w_pix_valid;
    logic              w_wr;
    logic              w_hs_fall;
    logic              w_vs_fall;
    logic              w_strip_end;
    logic              w_release;
    logic              w_ovf;

    assign w_first     = (r_state == S_ARMED) & i_cam_vsync;
    assign w_cap       = (r_state == S_CAPTURE) | w_first;
    assign w_col       = w_first ? '0 : r_col;
    assign w_ris       = w_first ? '0 : r_ris;
    assign w_rows      = w_first ? '0 : r_rows;
    assign w_sidx      = w_first ? '0 : r_sidx;
    assign w_fill      = w_first ? 1'b0 : r_fill;
    assign w_nfill     = ~w_fill;
    assign w_ris_nxt   = w_ris + 1'b1;
    assign w_rows_nxt  = w_rows + 1'b1;
    assign w_pix_valid = i_cam_hsync & i_cam_vsync;
    assign w_wr        = w_cap & w_pix_valid & (w_col < COL_END);
    assign w_hs_fall   = r_hsync_d & ~i_cam_hsync & i_cam_vsync;
    assign w_vs_fall   = r_vsync_d & ~i_cam_vsync;
    assign w_strip_end = w_hs_fall & (w_ris_nxt == RIS_END);
    assign w_release   = i_strip_done & r_full[r_present];
    // A bank released by the consumer in the same cycle is free for the next fill.
    assign w_ovf       = r_full[w_nfill] & ~(w_release & (r_present == w_nfill));

    always_ff @(posedge mclk) begin
        if (nreset) begin
            r_state      <= S_IDLE;
            r_hsync_d    <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_col        <= '0;
            r_ris        <= '0;
            r_rows       <= '0;
            r_sidx       <= '0;
            r_fill       <= 1'b0;
            r_present    <= 1'b0;
            r_full       <= 2'b00;
            r_snum[0]    <= '0;
            r_snum[1]    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_hsync_d    <= i_cam_hsync;
            r_vsync_d    <= i_cam_vsync;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;

            if (w_release) begin
                r_full[r_present] <= 1'b0;
                r_present         <= ~r_present;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_SYNC;
                        r_busy     <= 1'b1;
                        r_overflow <= 1'b0;
                        r_short    <= 1'b0;
                    end
                end
                S_SYNC: begin
                    if (!i_cam_vsync) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED, S_CAPTURE: begin
                    if (w_cap) begin
                        if (w_first) begin
                            r_state   <= S_CAPTURE;
                            r_col     <= '0;
                            r_ris     <= '0;
                            r_rows    <= '0;
                            r_sidx    <= '0;
                            r_fill    <= 1'b0;
                            r_present <= 1'b0;
                        end
                        if (w_wr) begin
                            r_wr_en   <= 1'b1;
                            r_wr_bank <= w_fill;
                            r_wr_addr <= strip_addr(w_ris, w_col);
                            r_wr_data <= i_cam_pixdata;
                            r_col     <= w_col + 1'b1;
                        end
                        if (w_hs_fall) begin
                            r_col  <= '0;
                            r_ris  <= w_ris_nxt;
                            r_rows <= w_rows_nxt;
                            if (w_rows_nxt == ROW_END) begin
                                r_state <= S_DRAIN;
                            end
                            if (w_strip_end) begin
                                r_full[w_fill] <= 1'b1;
                                r_snum[w_fill] <= w_sidx;
                                r_sidx         <= w_sidx + 1'b1;
                                r_ris          <= '0;
                                r_fill         <= w_nfill;
                                if (w_ovf) begin
                                    r_overflow <= 1'b1;
                                    r_state    <= S_DRAIN;
                                end
                            end
                        end else if (w_vs_fall) begin
                            // Truncated frame: the partial strip is never marked full.
                            r_short <= 1'b1;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_full == 2'b00) begin
                        r_frame_done <= 1'b1;
                        if (i_continuous) begin
                            r_state <= S_SYNC;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_bank     = r_wr_bank;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_strip_ready = r_full[r_present];
    assign o_strip_bank  = r_present;
    assign o_strip_index = r_snum[r_present];
    assign o_busy        = r_busy;
    assign o_frame_done  = r_frame_done;
    assign o_overflow    = r_overflow;
    assign o_short_frame = r_short;

endmodule

// File: tb/tb_hm01b0_strip_capture_ctrl.sv
// Scoreboard bench for hm01b0_strip_capture_ctrl with a scaled camera model
// (WIDTH+10 cycles per row, HEIGHT+2 rows per frame).
module tb_hm01b0_strip_capture_ctrl;

    localparam int W          = 16;
    localparam int H          = 32;
    localparam int SR         = 4;
    localparam int AW         = 6;
    localparam int ROW_CYC    = W + 10;
    localparam int FRAME_ROWS = H + 2;
    localparam int NSTRIPS    = H / SR;

    logic          mclk          = 1'b0;
    logic          nreset        = 1'b1;
    logic          i_cam_hsync   = 1'b0;
    logic          i_cam_vsync   = 1'b0;
    logic [7:0]    i_cam_pixdata = 8'h00;
    logic          i_start       = 1'b0;
    logic          i_continuous  = 1'b0;
    logic          i_strip_done  = 1'b0;
    logic          o_wr_en;
    logic          o_wr_bank;
    logic [AW-1:0] o_wr_addr;
    logic [7:0]    o_wr_data;
    logic          o_strip_ready;
    logic          o_strip_bank;
    logic [4:0]    o_strip_index;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_overflow;
    logic          o_short_frame;

    hm01b0_strip_capture_ctrl #(
        .WIDTH(W), .HEIGHT(H), .STRIP_ROWS(SR), .ADDR_W(AW)
    ) dut (
        .mclk(mclk), .nreset(nreset),
        .i_cam_hsync(i_cam_hsync), .i_cam_vsync(i_cam_vsync), .i_cam_pixdata(i_cam_pixdata),
        .i_start(i_start), .i_continuous(i_continuous), .i_strip_done(i_strip_done),
        .o_wr_en(o_wr_en), .o_wr_bank(o_wr_bank), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_strip_ready(o_strip_ready), .o_strip_bank(o_strip_bank), .o_strip_index(o_strip_index),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overflow(o_overflow),
        .o_short_frame(o_short_frame)
    );

    initial forever #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    int          wr_cnt   = 0;
    int          fd_cnt   = 0;
    logic [63:0] last_wr  = '0;
    int          pres_cnt = 0;
    int          pres_base = 0;
    int          served   = 0;
    int          man_req  = 0;
    bit          ack_en   = 1'b0;
    int          frame_no = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int fr, input int r, input int c);
        pix = 8'((r * 13) + (c * 5) + (fr * 29) + 1);
    endfunction

    // Write monitor: pop the scoreboard on every strobe, including the cycle stamp.
    initial forever begin
        @(negedge mclk);
        if (o_wr_en) begin
            wr_cnt++;
            last_wr = (64'(o_wr_bank) << 8) | 64'(o_wr_addr);
            if (exp_q.size() == 0)
                chk("wr_unexpected", {o_wr_bank, o_wr_addr}, 0);
            else
                chk("wr", (64'(cyc) << 24) | (64'(o_wr_bank) << 16) | (64'(o_wr_addr) << 8)
                          | 64'(o_wr_data), exp_q.pop_front());
        end
        if (o_frame_done) fd_cnt++;
    end

    // Consumer: acks each presented strip a few cycles later, either always or on request.
    initial forever begin
        @(negedge mclk);
        if (o_strip_ready && (ack_en || served < man_req)) begin
            if (!ack_en) served++;
            chk("present", {o_strip_index, o_strip_bank},
                {5'((pres_cnt - pres_base) % NSTRIPS), 1'((pres_cnt - pres_base) % 2)});
            pres_cnt++;
            repeat (4) @(negedge mclk);
            i_strip_done = 1'b1;
            @(negedge mclk);
            i_strip_done = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic reset_dut(input int n);
        @(negedge mclk);
        nreset = 1'b1;
        repeat (n) @(negedge mclk);
        nreset = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge mclk);
        i_start = 1'b1;
        @(negedge mclk);
        i_start = 1'b0;
    endtask

    // One camera frame; pixels of rows < wr_rows are pushed as expected writes.
    task automatic cam_frame(input int act_rows, input int hs_len, input bit exp_wr,
                             input int wr_rows, input int start_row, input int rst_row);
        for (int r = 0; r < FRAME_ROWS; r++) begin
            for (int c = 0; c < ROW_CYC; c++) begin
                @(negedge mclk);
                i_start = (r == start_row) && (c == 5);
                if (r == rst_row) nreset = (c == 0);
                i_cam_vsync   = (r < act_rows);
                i_cam_hsync   = (r < act_rows) && (c < hs_len);
                i_cam_pixdata = pix(frame_no, r, c);
                if (exp_wr && i_cam_hsync && r < wr_rows && c < W)
                    exp_q.push_back((64'(cyc + 1) << 24) | (64'((r / SR) % 2) << 16)
                                    | (64'((r % SR) * W + c) << 8) | 64'(i_cam_pixdata));
            end
        end
        frame_no++;
        i_start     = 1'b0;
        i_cam_vsync = 1'b0;
        i_cam_hsync = 1'b0;
    endtask

    int wr0, fd0;

    task automatic begin_test(input bit acks);
        reset_dut(5);
        ack_en    = acks;
        man_req   = served;
        pres_base = pres_cnt;
        wr0       = wr_cnt;
        fd0       = fd_cnt;
        exp_q.delete();
    endtask

    initial begin
        // Reset and idle: outputs quiet, no writes without start.
        begin_test(1'b1);
        idle(1);
        chk("reset_outputs", {o_wr_en, o_wr_bank, o_wr_addr, o_wr_data, o_strip_ready, o_strip_bank,
                              o_strip_index, o_busy, o_frame_done, o_overflow, o_short_frame}, 0);
        cam_frame(H, W, 1'b0, 0, -1, -1);
        chk("idle_wr_cnt", wr_cnt - wr0, 0);
        chk("idle_busy", o_busy, 0);

        // Single frame with prompt acks.
        begin_test(1'b1);
        pulse_start();
        chk("start_busy", o_busy, 1);
        cam_frame(H, W, 1'b1, H, -1, -1);
        idle(10);
        chk("frame_wr_cnt", wr_cnt - wr0, W * H);
        chk("frame_last_wr", last_wr, (64'(1) << 8) | 64'(SR * W - 1));
        chk("frame_presented", pres_cnt - pres_base, NSTRIPS);
        chk("frame_done_cnt", fd_cnt - fd0, 1);
        chk("frame_flags", {o_overflow, o_short_frame, o_busy}, 0);
        chk("frame_q_empty", exp_q.size(), 0);

        // Consumer stalls: overflow after the second strip.
        begin_test(1'b0);
        pulse_start();
        cam_frame(H, W, 1'b1, 2 * SR, -1, -1);
        idle(5);
        chk("ovf_wr_cnt", wr_cnt - wr0, 2 * SR * W);
        chk("ovf_flags", {o_overflow, o_short_frame, o_busy}, 3'b101);
        chk("ovf_present0", {o_strip_ready, o_strip_index, o_strip_bank}, {1'b1, 5'd0, 1'b0});
        chk("ovf_no_done", fd_cnt - fd0, 0);
        man_req = man_req + 1;
        idle(10);
        chk("ovf_present1", {o_strip_ready, o_strip_index, o_strip_bank}, {1'b1, 5'd1, 1'b1});
        chk("ovf_still_busy", o_busy, 1);
        man_req = man_req + 1;
        idle(10);
        chk("ovf_done_cnt", fd_cnt - fd0, 1);
        chk("ovf_idle", {o_busy, o_strip_ready}, 0);

        // Start issued mid-frame: nothing until the next frame boundary.
        begin_test(1'b1);
        cam_frame(H, W, 1'b0, 0, 10, -1);
        chk("mid_no_wr", wr_cnt - wr0, 0);
        chk("mid_busy", o_busy, 1);
        cam_frame(H, W, 1'b1, H, -1, -1);
        idle(10);
        chk("mid_wr_cnt", wr_cnt - wr0, W * H);
        chk("mid_done_cnt", fd_cnt - fd0, 1);

        // Continuous mode with overlong rows (extra pixels must be dropped).
        begin_test(1'b1);
        i_continuous = 1'b1;
        pulse_start();
        cam_frame(H, W + 3, 1'b1, H, -1, -1);
        cam_frame(H, W + 3, 1'b1, H, -1, -1);
        idle(10);
        chk("cont_wr_cnt", wr_cnt - wr0, 2 * W * H);
        chk("cont_done_cnt", fd_cnt - fd0, 2);
        chk("cont_presented", pres_cnt - pres_base, 2 * NSTRIPS);
        chk("cont_rearmed", o_busy, 1);
        i_continuous = 1'b0;

        // Truncated frame: partial strip discarded.
        begin_test(1'b1);
        pulse_start();
        cam_frame(3 * SR + 1, W, 1'b1, 3 * SR + 1, -1, -1);
        idle(10);
        chk("short_wr_cnt", wr_cnt - wr0, (3 * SR + 1) * W);
        chk("short_presented", pres_cnt - pres_base, 3);
        chk("short_flags", {o_overflow, o_short_frame, o_busy}, 3'b010);
        chk("short_done_cnt", fd_cnt - fd0, 1);

        // Reset in the middle of a capture.
        begin_test(1'b1);
        pulse_start();
        cam_frame(H, W, 1'b1, 10, -1, 10);
        idle(10);
        chk("rst_wr_cnt", wr_cnt - wr0, 10 * W);
        chk("rst_quiet", {o_busy, o_strip_ready, o_wr_en, o_frame_done}, 0);
        chk("rst_done_cnt", fd_cnt - fd0, 0);
        chk("rst_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/hm01b0_strip_capture_ctrl.md
Name: hm01b0_strip_capture_ctrl

Overview:
- Frame-capture sequencer between the HM01B0 camera pixel stream and the JPEG block-encoding pipeline.
- Arms on request, aligns to a frame boundary and writes pixels into a two-bank strip buffer of STRIP_ROWS rows × WIDTH columns.
- Each filled bank is handed to the downstream consumer through a ready/done handshake.
- Detects consumer overrun and truncated frames.

Parameters:
- WIDTH, 320, active pixels per row
- HEIGHT, 240, active rows per frame; multiple of STRIP_ROWS
- STRIP_ROWS, 8, rows per strip (one JPEG MCU row)
- ADDR_W, 12, bank address width; 2^ADDR_W >= STRIP_ROWS*WIDTH

Ports:
- mclk  in  1  clock; camera stream is synchronous to it
- nreset  in  1  reset, synchronous, active-high (despite the name)
- cam_hsync  in  1  high during active pixels of a row
- cam_vsync  in  1  high during active rows of a frame
- cam_pixdata  in  8  pixel, valid when cam_hsync & cam_vsync
- start  in  1  pulse: capture next full frame
- continuous  in  1  re-arm automatically after each frame
- strip_done  in  1  consumer pulse: current presented bank released
- wr_en  out  1  strip-buffer write strobe
- wr_bank  out  1  bank written
- wr_addr  out  ADDR_W  row_in_strip*WIDTH + col
- wr_data  out  8  pixel
- strip_ready  out  1  presented bank full
- strip_bank  out  1  bank presented
- strip_index  out  5  strip number within frame, 0..HEIGHT/STRIP_ROWS-1
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame (good or aborted)
- overflow  out  1  sticky: fill needed a bank still held by consumer
- short_frame  out  1  sticky: vsync fell before HEIGHT rows

Behaviour:
- Reset: state IDLE; all outputs 0; both banks empty; fill bank = 0, present bank = 0; counters 0; sticky flags cleared. Reset mid-capture abandons the frame; no writes occur until a new start.
- pix_valid = cam_hsync & cam_vsync, sampled directly at posedge mclk. hsync_d and vsync_d are registered copies used for edge detection.
- FSM:
  - IDLE: on start → SYNC; clears overflow and short_frame. start is ignored in any other state.
  - SYNC: wait for cam_vsync == 0, then → ARMED. Guarantees capture never begins mid-frame.
  - ARMED: the first cycle with cam_vsync == 1 → CAPTURE. That cycle is itself processed as a capture cycle, so pixel (0,0) is written.
  - CAPTURE:
    - Each pix_valid cycle with col < WIDTH: wr_en=1, wr_bank=fill bank, wr_addr=row_in_strip*WIDTH+col, wr_data=pixel. Latency is 1 cycle, with all outputs registered.
    - col increments on each valid pixel and saturates at WIDTH; pixels beyond WIDTH are dropped.
    - col clears on hsync falling edge while vsync is high. That edge also increments row_in_strip and the total row count.
    - When row_in_strip reaches STRIP_ROWS: mark the fill bank full with its strip number, clear row_in_strip, then toggle the fill bank.
    - If the toggled-to bank is already full: set overflow, stop writing, → DRAIN.
    - When total rows == HEIGHT → DRAIN.
    - vsync falling edge with rows < HEIGHT: set short_frame, discard the partial strip (never presented), → DRAIN.
  - DRAIN: no writes; wait for both banks empty, then pulse frame_done. Next state is SYNC if continuous, else IDLE.
- Presentation:
  - strip_ready = full[present bank]; strip_bank and strip_index reflect the presented bank's stored strip number.
  - strip_done while strip_ready: clear that bank's full flag and toggle the present bank. Takes effect the next cycle.
  - strip_done while !strip_ready: ignored.
  - Fill completion on one bank and strip_done on the other in the same cycle are both honoured.
- strip_index is a 5-bit counter cleared at every frame start (ARMED→CAPTURE).
- busy = (state != IDLE), registered.

Test Plan (camera model: 330 cycles/row with 320 active, 242 rows/frame with 240 active):
- Reset held 5 cycles, then released with no start -> all outputs 0, busy 0, no wr_en for 100k cycles.
- start in IDLE; consumer pulses strip_done 5 cycles after strip_ready -> exactly 76800 wr_en; first write addr 0 carries pixel(0,0) one cycle after sample; last write bank 1 addr 2559; strip_index 0..29 with banks alternating 0,1; one frame_done; overflow=0, short_frame=0.
- Consumer never acks -> strip 0 (bank 0) presented; overflow sets at the hsync fall ending row 15; wr_en stays 0 afterwards; after two strip_done pulses, frame_done pulses once; busy then 0.
- start issued during active row 100 -> no writes in the current frame; first wr_en addr 0 at the next frame's (0,0).
- continuous=1, prompt acks -> two frames: two frame_done pulses, 153600 writes, strip_index restarts at 0 for frame 2.
- Model drops vsync after 100 rows -> short_frame=1; 12 strips presented, rows 96-99 discarded; frame_done after last ack. Separately, nreset pulsed at row 50 -> wr_en 0, busy 0, banks empty.
